// File: rtl/hb_ce_sched_if.sv
// hb_ce_sched_if: control and strobe bundle between the SoC and the clock-enable scheduler.
interface hb_ce_sched_if #(
    parameter int STAGES = 3,
    parameter int DIV_W  = 16
);
    logic              enable;
    logic              load;
    logic [DIV_W-1:0]  div;
    logic [STAGES-1:0] ce;
    logic              busy;
    logic              cfg_err;
    modport master (output enable, load, div, input ce, busy, cfg_err);
    modport slave  (input enable, load, div, output ce, busy, cfg_err);
endinterface

// File: rtl/hb_ce_sched.sv
// hb_ce_sched: per-stage ce strobes for a halfband interpolator cascade, each stage at half the next one's rate.
// Define HB_CE_SCHED_STAGGER_EN to offset adjacent stages by STAGGER cycles via per-stage countdowns.
module hb_ce_sched #(
    parameter int STAGES    = 3,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 3250,
    parameter int MIN_GAP   = 124,
    parameter int STAGGER   = 8
) (
    input logic          clk,
    input logic          reset,
    hb_ce_sched_if.slave bus
);
`ifdef HB_CE_SCHED_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif
    localparam logic [DIV_W-1:0] GAP  = DIV_W'(MIN_GAP);
    localparam logic [DIV_W-1:0] SPAN = DIV_W'((STAGES-1)*STAGGER);
    logic [DIV_W-1:0]  div_r, cnt;
    logic [STAGES-2:0] frm;
    logic [STAGES-1:0] q, ce;
    logic              cfg_err, clr, tick;
    function automatic logic legal(input logic [DIV_W-1:0] d);
        return d >= GAP && d != '0 && (!STAG || d > SPAN);
    endfunction
    assign clr  = bus.load || !bus.enable || cfg_err;
    assign tick = !clr && cnt == div_r - DIV_W'(1);
    // stage k runs every 2^(STAGES-1-k) base ticks, aligned to frame 0
    for (genvar k = 0; k < STAGES; k++) begin : g_q
        assign q[k] = (32'(frm) & ((32'd1 << (STAGES-1-k)) - 32'd1)) == 32'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r   <= DIV_W'(DIV_RESET);
            cfg_err <= !legal(DIV_W'(DIV_RESET));
            cnt     <= '0;
            frm     <= '0;
        end else begin
            if (bus.load) div_r <= bus.div;
            cfg_err <= !legal(bus.load ? bus.div : div_r);
            cnt     <= (clr || tick) ? '0 : cnt + DIV_W'(1);
            frm     <= clr ? '0 : tick ? frm + (STAGES-1)'(1) : frm;
        end
    end
`ifdef HB_CE_SCHED_STAGGER_EN
    localparam int CW = $clog2((STAGES-1)*STAGGER+2);
    logic [CW-1:0]     cd [STAGES];
    logic [STAGES-1:0] pend;
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset || clr) begin
                cd[i] <= '0;
                ce[i] <= 1'b0;
            end else begin
                ce[i] <= (tick && q[i] && i*STAGGER == 0) || cd[i] == CW'(1);
                cd[i] <= (tick && q[i]) ? CW'(i*STAGGER) : (cd[i] != '0 ? cd[i] - CW'(1) : '0);
            end
        end
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_pend
        assign pend[k] = cd[k] != '0;
    end
    assign bus.busy = |pend;
`else
    always_ff @(posedge clk) begin
        ce <= (reset || !tick) ? '0 : q;
    end
    assign bus.busy = 1'b0;
`endif
    assign bus.ce      = ce;
    assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_hb_ce_sched.sv
// tb_hb_ce_sched: randomized bench for hb_ce_sched against a time-based strobe schedule model.
module tb_hb_ce_sched;
    localparam int STAGES    = 3;
    localparam int DIV_W     = 16;
    localparam int DIV_RESET = 3250;
    localparam int MIN_GAP   = 124;
`ifdef HB_CE_SCHED_STAGGER_EN
    localparam int STAGGER = 8;
    localparam int STG     = 8;
`else
    localparam int STAGGER = 8;
    localparam int STG     = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    hb_ce_sched_if #(.STAGES(STAGES), .DIV_W(DIV_W)) bus ();
    hb_ce_sched #(.STAGES(STAGES), .DIV_W(DIV_W), .DIV_RESET(DIV_RESET), .MIN_GAP(MIN_GAP), .STAGGER(STAGGER))
        dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_err = 0;
    longint t = 0;
    longint s = 1;
    longint fire [STAGES];
    int unsigned md = DIV_RESET;
    bit merr = 1'b0;
    logic [STAGES-1:0] ece;
    bit ebusy;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, t);
        end
    endtask
    function automatic bit legal_m(input int unsigned d);
        return d >= MIN_GAP && d != 0 && (STG == 0 || d > (STAGES-1)*STG);
    endfunction
    // Strobes are absolute fire times: base tick j of a run starting at s lands on s+(j+1)*md-1
    task automatic model(input bit r, input bit en, input bit ld, input int unsigned dv);
        if (r || ld || !en || merr) begin
            if (r) begin
                md   = DIV_RESET;
                merr = !legal_m(DIV_RESET);
            end else if (ld) begin
                md   = dv;
                merr = !legal_m(dv);
            end
            for (int k = 0; k < STAGES; k++) fire[k] = -1;
            s = t + 1;
        end else if ((t - s) % md == md - 1) begin
            for (int k = 0; k < STAGES; k++)
                if (((t - s) / md) % (64'd1 << (STAGES-1-k)) == 0) fire[k] = t + 1 + k*STG;
        end
        ebusy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            ece[k] = fire[k] == t + 1;
            if (fire[k] > t + 1) ebusy = 1'b1;
        end
    endtask
    task automatic cyc(input bit r, input bit en, input bit ld, input int unsigned dv);
        reset = r;
        bus.enable = en;
        bus.load = ld;
        bus.div = DIV_W'(dv);
        model(r, en, ld, dv);
        @(posedge clk);
        #1;
        t++;
        chk("ce", 32'(bus.ce), 32'(ece));
        chk("busy", 32'(bus.busy), 32'(ebusy));
        chk("cfg_err", 32'(bus.cfg_err), 32'(merr));
    endtask
    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b0, 0);
    endtask
    task automatic wait_ce0(input string tag);
        int w = 0;
        while (bus.ce[0] !== 1'b1 && w < 20000) begin
            cyc(1'b0, 1'b1, 1'b0, 0);
            w++;
        end
        chk(tag, 32'(bus.ce[0]), 32'd1);
    endtask
    int unsigned tbl [8] = '{0, 16, 17, 123, 124, 125, 200, 333};
    initial begin
        for (int k = 0; k < STAGES; k++) fire[k] = -1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.div = '0;
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        run(16300, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 100);
        run(20000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 200);
        run(1000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 124);
        run(600, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 123);
        run(300, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 400);
        wait_ce0("wait_ce0_pend");
        run(2, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 500);
        run(1200, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 400);
        run(150, 1'b1);
        run(10, 1'b0);
        run(1300, 1'b1);
        // load landing exactly on the base tick of the previous ratio
        cyc(1'b0, 1'b1, 1'b1, 300);
        run(299, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 250);
        run(800, 1'b1);
        wait_ce0("wait_ce0_rst");
        run(1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 0);
        run(3300, 1'b1);
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0: cyc(1'b0, 1'b1, 1'b1, $urandom_range(0, 1) ? tbl[$urandom_range(0, 7)] : $urandom_range(124, 600));
                1: run($urandom_range(1, 15), 1'b0);
                default: ;
            endcase
            run($urandom_range(100, 800), 1'b1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
